i2c_regfile_slave: RTL and testbench

I2C_REGFILE_SLAVE -- requirements
Module: i2c_regfile_slave

---
 rtl/i2c_regfile_slave.sv | 131 +++++++++++++
 tb/tb_i2c_regfile_slave.sv | 137 +++++++++++++
 2 files changed

// File: rtl/i2c_regfile_slave.sv
// i2c_regfile_slave: I2C target exposing NUM_REGS byte registers through an auto-incrementing pointer
module i2c_regfile_slave #(
  parameter logic [6:0] I2C_ADDR = 7'h64,
  parameter int NUM_REGS = 4,
  parameter int SYNC_STAGES = 3,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [NUM_REGS*8-1:0] rd_data,
  output logic                  wr_valid,
  output logic [AW-1:0]         wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);
  localparam logic [3:0] S_IDLE = 4'd0, S_ADDR = 4'd1, S_ADDR_ACK = 4'd2, S_PTR = 4'd3,
    S_PTR_ACK = 4'd4, S_WDATA = 4'd5, S_WDATA_ACK = 4'd6, S_RDATA = 4'd7, S_MACK = 4'd8;
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl, sda, scl_d, sda_d;
  logic scl_rise, scl_fall, start_c, stop_c, byte_done;
  logic [3:0] state, cnt;
  logic [7:0] shreg, rd_byte, rd_nx;
  logic rw;
  logic [AW-1:0] ptr, ptr_nx;
  assign scl = scl_s[SYNC_STAGES-1];
  assign sda = sda_s[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c = scl & scl_d & sda_d & ~sda;
  assign stop_c = scl & scl_d & ~sda_d & sda;
  assign byte_done = scl_fall && cnt == 4'd8;
  assign ptr_nx = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign rd_byte = rd_data[{ptr, 3'b000} +: 8];
  assign rd_nx = rd_data[{ptr_nx, 3'b000} +: 8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= S_IDLE;
      cnt <= '0;
      shreg <= '0;
      rw <= 1'b0;
      ptr <= '0;
      sda_oe <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl_in};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda_in};
      scl_d <= scl;
      sda_d <= sda;
      wr_valid <= 1'b0;
      if (stop_c) begin
        state <= S_IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (start_c) begin
        state <= S_ADDR;
        cnt <= '0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], sda};
              cnt <= cnt + 4'd1;
            end else if (byte_done) begin
              // The ACK is driven from the fall that ends bit 8 until the next fall
              if (state == S_ADDR) begin
                sda_oe <= shreg[7:1] == I2C_ADDR;
                busy <= shreg[7:1] == I2C_ADDR;
                rw <= shreg[0];
                state <= shreg[7:1] == I2C_ADDR ? S_ADDR_ACK : S_IDLE;
              end else if (state == S_PTR) begin
                sda_oe <= 1'b1;
                ptr <= int'(shreg) < NUM_REGS ? shreg[AW-1:0] : '0;
                state <= S_PTR_ACK;
              end else begin
                sda_oe <= 1'b1;
                wr_valid <= 1'b1;
                wr_addr <= ptr;
                wr_data <= shreg;
                ptr <= ptr_nx;
                state <= S_WDATA_ACK;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            cnt <= '0;
            shreg <= rw ? rd_byte : shreg;
            sda_oe <= rw & ~rd_byte[7];
            state <= rw ? S_RDATA : S_PTR;
          end
          S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            cnt <= '0;
            state <= S_WDATA;
          end
          S_RDATA: begin
            if (scl_rise) begin
              shreg <= {shreg[6:0], 1'b0};
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              sda_oe <= cnt != 4'd8 && !shreg[7];
              state <= cnt == 4'd8 ? S_MACK : S_RDATA;
            end
          end
          S_MACK: if (scl_rise) begin
            if (sda) begin
              state <= S_IDLE;
              busy <= 1'b0;
            end else begin
              ptr <= ptr_nx;
              shreg <= rd_nx;
              cnt <= '0;
              state <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_regfile_slave.sv
// tb_i2c_regfile_slave: directed bus-master sequences against the register-file target
module tb_i2c_regfile_slave;
  logic clk = 1'b0, rst = 1'b1, scl_drv = 1'b1, sda_drv = 1'b1;
  logic [31:0] rd_data = 32'h44332211;
  logic sda_oe, wr_valid, busy, sda_bus, ack;
  logic [1:0] wr_addr;
  logic [7:0] wr_data, rx;
  logic [1:0] wr_a [16];
  logic [7:0] wr_d [16];
  int checks = 0, errors = 0, wr_n = 0, oe_n = 0, oe_mark;
  assign sda_bus = sda_drv & ~sda_oe;
  always #5 clk = ~clk;
  i2c_regfile_slave dut (.clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy));
  always @(negedge clk) begin
    if (wr_valid && wr_n < 16) begin
      wr_a[wr_n] <= wr_addr;
      wr_d[wr_n] <= wr_data;
    end
    if (wr_valid) wr_n <= wr_n + 1;
    if (sda_oe) oe_n <= oe_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic q();
    repeat (10) @(posedge clk);
  endtask
  task automatic i2c_start();
    sda_drv = 1'b1; q(); scl_drv = 1'b1; q(); sda_drv = 1'b0; q(); scl_drv = 1'b0; q();
  endtask
  task automatic i2c_stop();
    sda_drv = 1'b0; q(); scl_drv = 1'b1; q(); sda_drv = 1'b1; q();
  endtask
  task automatic write_bit(input logic b);
    sda_drv = b; q(); scl_drv = 1'b1; q(); q(); scl_drv = 1'b0; q();
  endtask
  task automatic read_bit(output logic b);
    sda_drv = 1'b1; q(); scl_drv = 1'b1; q(); b = sda_bus; q(); scl_drv = 1'b0; q();
  endtask
  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
  endtask
  task automatic read_byte(output logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
    write_bit(a);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    q();
    // Read three bytes from pointer 0
    i2c_start();
    write_byte(8'hC9, ack); chk("rd_addr_ack", ack, 0);
    chk("rd_busy", busy, 1);
    read_byte(rx, 1'b0); chk("rd_b0", rx, 8'h11);
    read_byte(rx, 1'b0); chk("rd_b1", rx, 8'h22);
    read_byte(rx, 1'b1); chk("rd_b2", rx, 8'h33);
    chk("rd_nack_oe", sda_oe, 0);
    chk("rd_nack_busy", busy, 0);
    i2c_stop();
    // Write two bytes from pointer 1
    i2c_start();
    write_byte(8'hC8, ack); chk("wr_addr_ack", ack, 0);
    write_byte(8'h01, ack); chk("wr_ptr_ack", ack, 0);
    write_byte(8'hA5, ack); chk("wr_d0_ack", ack, 0);
    write_byte(8'h3C, ack); chk("wr_d1_ack", ack, 0);
    chk("wr_busy", busy, 1);
    i2c_stop();
    chk("wr_stop_busy", busy, 0);
    chk("wr_count", wr_n, 2);
    chk("wr0_addr", wr_a[0], 1); chk("wr0_data", wr_d[0], 8'hA5);
    chk("wr1_addr", wr_a[1], 2); chk("wr1_data", wr_d[1], 8'h3C);
    // Pointer-only write, repeated START, read wraps 3 -> 0
    i2c_start();
    write_byte(8'hC8, ack); chk("rs_addr_ack", ack, 0);
    write_byte(8'h03, ack); chk("rs_ptr_ack", ack, 0);
    i2c_start();
    write_byte(8'hC9, ack); chk("rs_raddr_ack", ack, 0);
    read_byte(rx, 1'b0); chk("rs_b0", rx, 8'h44);
    read_byte(rx, 1'b1); chk("rs_b1", rx, 8'h11);
    i2c_stop();
    chk("rs_no_write", wr_n, 2);
    // Foreign address
    oe_mark = oe_n;
    i2c_start();
    write_byte(8'hCA, ack); chk("na_ack", ack, 1);
    chk("na_busy", busy, 0);
    write_byte(8'h55, ack); chk("na_data_ack", ack, 1);
    i2c_stop();
    chk("na_oe_never", oe_n, oe_mark);
    chk("na_no_write", wr_n, 2);
    // Out-of-range pointer clamps to 0
    i2c_start();
    write_byte(8'hC8, ack); chk("clamp_addr_ack", ack, 0);
    write_byte(8'h09, ack); chk("clamp_ptr_ack", ack, 0);
    write_byte(8'h77, ack); chk("clamp_d_ack", ack, 0);
    i2c_stop();
    chk("clamp_count", wr_n, 3);
    chk("clamp_addr", wr_a[2], 0); chk("clamp_data", wr_d[2], 8'h77);
    // Reset during bit 4 of a read of register 1 (0x22)
    i2c_start();
    write_byte(8'hC9, ack); chk("mr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) read_bit(rx[i]);
    chk("mr_bits", rx[2:0], 3'b100);
    chk("mr_oe_before", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_oe_async", sda_oe, 0);
    chk("mr_busy", busy, 0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    q();
    i2c_stop();
    i2c_start();
    write_byte(8'hC8, ack); chk("mr2_addr_ack", ack, 0);
    write_byte(8'h02, ack); chk("mr2_ptr_ack", ack, 0);
    write_byte(8'h99, ack); chk("mr2_d_ack", ack, 0);
    i2c_stop();
    chk("mr2_count", wr_n, 4);
    chk("mr2_addr", wr_a[3], 2); chk("mr2_data", wr_d[3], 8'h99);
    chk("mr2_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
